// File: rtl/execute_cycle_if.sv
// Execute-stage bus: decode-side E inputs, forwarding inputs, and the
// combinational branch outputs plus EX/MEM register outputs.
interface execute_cycle_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  RegWriteE;
    logic                  ResultSrcE;
    logic                  MemWriteE;
    logic                  BranchE;
    logic                  ALUSrcE;
    logic [2:0]            ALUcontrolE;
    logic [XLEN-1:0]       RD1E;
    logic [XLEN-1:0]       RD2E;
    logic [XLEN-1:0]       ImmExtE;
    logic [XLEN-1:0]       PCE;
    logic [XLEN-1:0]       PCPlus4E;
    logic [REG_ADDR_W-1:0] RdE;
    logic [1:0]            ForwardAE;
    logic [1:0]            ForwardBE;
    logic [XLEN-1:0]       ResultW;

    logic                  PCSrcE;
    logic [XLEN-1:0]       PCTargetE;
    logic                  RegWriteM;
    logic                  ResultSrcM;
    logic                  MemWriteM;
    logic [XLEN-1:0]       ALUResultM;
    logic [XLEN-1:0]       WriteDataM;
    logic [XLEN-1:0]       PCPlus4M;
    logic [REG_ADDR_W-1:0] RdM;

    // The upstream decode/hazard logic drives E-side signals.
    modport master (
        output RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUcontrolE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, ResultSrcM, MemWriteM,
               ALUResultM, WriteDataM, PCPlus4M, RdM
    );

    // The execute stage itself.
    modport slave (
        input  RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE, ALUcontrolE,
               RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, ResultSrcM, MemWriteM,
               ALUResultM, WriteDataM, PCPlus4M, RdM
    );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32 pipeline: operand forwarding, ALU,
// beq resolution and the EX/MEM pipeline register.
module execute_cycle #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    execute_cycle_if.slave  bus
);
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // Select 2'b10 forwards this stage's own registered result from the previous cycle.
    always_comb begin
        src_a = bus.RD1E;
        case (bus.ForwardAE)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = bus.ALUResultM;
            default: src_a = bus.RD1E;
        endcase
    end

    always_comb begin
        write_data = bus.RD2E;
        case (bus.ForwardBE)
            2'b01:   write_data = bus.ResultW;
            2'b10:   write_data = bus.ALUResultM;
            default: write_data = bus.RD2E;
        endcase
    end

    assign src_b = bus.ALUSrcE ? bus.ImmExtE : write_data;

    always_comb begin
        alu_result = '0;
        case (bus.ALUcontrolE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero          = (alu_result == '0);
    assign bus.PCSrcE    = bus.BranchE & zero;
    assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

    // No stall or flush: the register captures every cycle once out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.RegWriteM  <= 1'b0;
            bus.ResultSrcM <= 1'b0;
            bus.MemWriteM  <= 1'b0;
            bus.ALUResultM <= '0;
            bus.WriteDataM <= '0;
            bus.PCPlus4M   <= '0;
            bus.RdM        <= '0;
        end else begin
            bus.RegWriteM  <= bus.RegWriteE;
            bus.ResultSrcM <= bus.ResultSrcE;
            bus.MemWriteM  <= bus.MemWriteE;
            bus.ALUResultM <= alu_result;
            bus.WriteDataM <= write_data;
            bus.PCPlus4M   <= bus.PCPlus4E;
            bus.RdM        <= bus.RdE;
        end
    end
endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
Execute stage of the 5-stage pipelined RV32 core. It sits directly downstream of the decode stage and consumes its E-side outputs.
- Applies hazard-unit forwarding selects to the operands.
- Performs the ALU operation and computes the branch target and taken decision.
- Registers results into the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width for operands, PC and results.
- REG_ADDR_W, 5, register-index width.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; clears EX/MEM register.
- RegWriteE  in  1  register-file write enable from decode.
- ResultSrcE  in  1  writeback select (1 = memory data).
- MemWriteE  in  1  data-memory write enable.
- BranchE  in  1  instruction is beq.
- ALUSrcE  in  1  ALU B source (1 = ImmExtE).
- ALUcontrolE  in  3  ALU operation code.
- RD1E, RD2E  in  XLEN  register operands read in decode.
- ImmExtE  in  XLEN  sign-extended immediate.
- PCE, PCPlus4E  in  XLEN  PC and PC+4 of the instruction.
- RdE  in  REG_ADDR_W  destination register.
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit.
- ResultW  in  XLEN  writeback-stage result for forwarding.
- PCSrcE  out  1  branch taken (combinational).
- PCTargetE  out  XLEN  branch target (combinational).
- RegWriteM, ResultSrcM, MemWriteM  out  1  registered controls.
- ALUResultM, WriteDataM, PCPlus4M  out  XLEN  registered data.
- RdM  out  REG_ADDR_W  registered destination.

Behaviour:
- Operand A select: ForwardAE=00 gives RD1E; 01 gives ResultW; 10 gives ALUResultM (the registered output of this block); 11 is treated as 00.
- Operand B select: ForwardBE is decoded identically using RD2E. The selected value is WriteDataE. SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- ALU codes:
  - 000: A+B.
  - 001: A−B.
  - 010: A&B.
  - 011: A|B.
  - 101: set-less-than signed. Result 32'h1 if $signed(A)<$signed(B), else 0.
  - 100, 110, 111: result 0.
- Add and subtract wrap modulo 2^XLEN; no overflow flag.
- Zero = (ALUResultE == 0).
- PCSrcE = BranchE & Zero.
- PCTargetE = PCE + ImmExtE, modulo 2^XLEN, computed regardless of BranchE.
- PCSrcE and PCTargetE are purely combinational, zero latency, and valid in the same cycle as the E inputs.
- EX/MEM register: on each rising clk with rst high, the following are captured unconditionally (no stall or flush input):
  - RegWriteE, ResultSrcE, MemWriteE, RdE, PCPlus4E.
  - ALUResultE into ALUResultM.
  - WriteDataE (post-forwarding, pre-ALUSrc) into WriteDataM.
- Latency from E inputs to M outputs is exactly 1 cycle.
- BranchE and ALUSrcE are not propagated past this stage.
- Reset: rst low clears all M outputs to 0 immediately, without waiting for clk. While rst is low, the register holds 0. The first capture happens at the first rising edge after rst returns high.
- Combinational outputs during reset: PCSrcE and PCTargetE still follow the inputs. Because ALUResultM is 0, ForwardAE=10 supplies 0.
- Reset asserted mid-operation: in-flight EX/MEM contents are lost; no partial update.
- Back-to-back dependency: ForwardAE=10 in cycle N uses the ALUResultM that was captured at the edge ending cycle N−1.
- A bubble from the decode-stage reset (all controls 0) propagates as RegWriteM=0 and MemWriteM=0.

Test Plan:
- Reset: drive rst=0 mid-cycle with non-zero state -> all M outputs read 0 before the next clk edge. Release, then apply RD1E=5, RD2E=2, ALUcontrolE=000, RegWriteE=1, RdE=3 -> after 1 edge ALUResultM=7, RegWriteM=1, RdM=3.
- ALU ops with A=32'h0000000C, B=32'h0000000A:
  - 000 -> 32'h16.
  - 001 -> 32'h2.
  - 010 -> 32'h8.
  - 011 -> 32'hE.
  - 101 with A=32'hFFFFFFFF, B=1 -> 1.
  - 110 -> 0.
- Forwarding: RD1E=1, ResultW=40, ALUResultM=100. ForwardAE=01 with ADD of RD2E=2 -> ALUResultE=42. ForwardAE=10 -> 102. ForwardAE=11 -> 3. ForwardBE=10 with MemWriteE=1 -> WriteDataM=100.
- Immediate path: ALUSrcE=1, ImmExtE=32'hFFFFFFFC, RD1E=16, RD2E=9 -> ALUResultM=12, WriteDataM=9.
- Branch: BranchE=1, ALUcontrolE=001, RD1E=RD2E=11, PCE=32'h20, ImmExtE=32'hFFFFFFF8 -> PCSrcE=1, PCTargetE=32'h18 in the same cycle. With RD2E=10 -> PCSrcE=0. With BranchE=0 and equal operands -> PCSrcE=0.
- Wrap: ADD 32'hFFFFFFFF+1 -> ALUResultM=0. PCE=32'hFFFFFFFC, ImmExtE=8 -> PCTargetE=32'h4.
